// File: rtl/ysyx_23060236_scoreboard.sv
// ---------------------------------------------------------------------------
// ysyx_23060236_scoreboard
//
// Register-hazard scoreboard for a single-issue pipeline with 16 architectural
// registers (x0 hard-wired to zero). Each register r = 1..15 has a 2-bit count
// of in-flight writes. A source operand that is still pending stalls issue.
// The exception is an operand whose only pending write retires in this same
// cycle: that operand is forwarded from the writeback path instead.
//
// Handshake: issue_valid/issue_ready follow strict valid/ready semantics.
// An instruction is accepted on a rising clock edge where both are high.
// issue_ready is purely combinational and never depends on issue_valid.
// While issue_valid is low, nothing is accepted and no counter is touched.
//
// Ports
//   clock, reset                 sole clock; async active-high reset
//   issue_valid/rd/wen           instruction offered by decode
//   rs1, rs2, need_rs1/2         its source registers and whether it reads them
//   wb_valid, wb_rd, wb_wen      writeback retiring this cycle
//   flush                        mispredict kill; all counters clear next edge
//   issue_ready                  offered instruction may be accepted
//   fwd_rs1, fwd_rs2             take that source from the writeback value
//   busy_mask[15:0]              bit r set while register r has pending writes
//
// Optional feature (macro YSYX_23060236_SB_PERF_EN):
//   perf_stall_cycles[31:0]      number of cycles with issue_valid & stall
//   perf_stall_events[31:0]      number of rising edges of that condition
// ---------------------------------------------------------------------------
module ysyx_23060236_scoreboard (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [3:0]  issue_rd,
  input  logic        issue_wen,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  input  logic        need_rs1,
  input  logic        need_rs2,
  input  logic        wb_valid,
  input  logic [3:0]  wb_rd,
  input  logic        wb_wen,
  input  logic        flush,
  output logic        issue_ready,
  output logic        fwd_rs1,
  output logic        fwd_rs2,
  output logic [15:0] busy_mask
`ifdef YSYX_23060236_SB_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_stall_events
`endif
);

  logic [1:0]  r_cnt [1:15];
  logic [1:0]  w_cnt [16];     // view with x0 pinned to zero
  logic [15:0] w_retire;
  logic [15:0] w_inc;
  logic        w_accept;
  logic        w_hit1;
  logic        w_hit2;
  logic        w_full_wr;
  logic        w_stall;

  always_comb begin
    w_cnt[0] = 2'd0;
    for (int r = 1; r < 16; r++) begin
      w_cnt[r] = r_cnt[r];
    end
  end

  // Per-register retire and increment strobes; x0 never moves.
  always_comb begin
    w_retire = '0;
    w_inc    = '0;
    for (int r = 1; r < 16; r++) begin
      w_retire[r] = wb_valid & wb_wen & (wb_rd == 4'(r));
      w_inc[r]    = w_accept & issue_wen & (issue_rd == 4'(r));
    end
  end

  always_comb begin
    w_hit1    = need_rs1 & (rs1 != 4'd0) & (w_cnt[rs1] != 2'd0);
    w_hit2    = need_rs2 & (rs2 != 4'd0) & (w_cnt[rs2] != 2'd0);
    // Forward only when the retiring write is the last one outstanding;
    // with a younger write still in flight the writeback value is stale.
    fwd_rs1   = w_hit1 & w_retire[rs1] & (w_cnt[rs1] == 2'd1);
    fwd_rs2   = w_hit2 & w_retire[rs2] & (w_cnt[rs2] == 2'd1);
    // A saturated counter cannot take another write; block it at issue.
    w_full_wr = issue_wen & (issue_rd != 4'd0) & (w_cnt[issue_rd] == 2'd3);
    w_stall   = (w_hit1 & ~fwd_rs1) | (w_hit2 & ~fwd_rs2) | w_full_wr;
    issue_ready = ~w_stall & ~flush;
    w_accept  = issue_valid & issue_ready;
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < 16; r++) begin
      busy_mask[r] = (w_cnt[r] != 2'd0);
    end
  end

  // Accept and retire on the same register cancel, even from zero (net 0).
  // A lone retire on an idle register is dropped so the count never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 1; r < 16; r++) begin
        r_cnt[r] <= 2'd0;
      end
    end else if (flush) begin
      for (int r = 1; r < 16; r++) begin
        r_cnt[r] <= 2'd0;
      end
    end else begin
      for (int r = 1; r < 16; r++) begin
        case ({w_inc[r], w_retire[r]})
          2'b10:   r_cnt[r] <= r_cnt[r] + 2'd1;
          2'b01:   if (r_cnt[r] != 2'd0) r_cnt[r] <= r_cnt[r] - 2'd1;
          default: r_cnt[r] <= r_cnt[r];
        endcase
      end
    end
  end

`ifdef YSYX_23060236_SB_PERF_EN
  logic        w_stall_cond;
  logic        r_stall_d;
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_events;

  assign w_stall_cond = issue_valid & w_stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_d     <= 1'b0;
      r_perf_cycles <= 32'd0;
      r_perf_events <= 32'd0;
    end else begin
      r_stall_d <= w_stall_cond;
      if (w_stall_cond) r_perf_cycles <= r_perf_cycles + 32'd1;
      if (w_stall_cond & ~r_stall_d) r_perf_events <= r_perf_events + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_cycles;
  assign perf_stall_events = r_perf_events;
`endif

endmodule

// File: tb/tb_ysyx_23060236_scoreboard.sv
// ---------------------------------------------------------------------------
// Bench for ysyx_23060236_scoreboard: directed table, reset corner cases and
// randomized traffic against a count-per-register reference model.
// Performance counter checks compile in with YSYX_23060236_SB_PERF_EN.
// ---------------------------------------------------------------------------
module tb_ysyx_23060236_scoreboard;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [3:0]  issue_rd;
  logic        issue_wen;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic        need_rs1;
  logic        need_rs2;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic        wb_wen;
  logic        flush;
  logic        issue_ready;
  logic        fwd_rs1;
  logic        fwd_rs2;
  logic [15:0] busy_mask;
`ifdef YSYX_23060236_SB_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_stall_events;
`endif

  always #5 clock = ~clock;

  ysyx_23060236_scoreboard dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_wen   (issue_wen),
    .rs1         (rs1),
    .rs2         (rs2),
    .need_rs1    (need_rs1),
    .need_rs2    (need_rs2),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_wen      (wb_wen),
    .flush       (flush),
    .issue_ready (issue_ready),
    .fwd_rs1     (fwd_rs1),
    .fwd_rs2     (fwd_rs2),
    .busy_mask   (busy_mask)
`ifdef YSYX_23060236_SB_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_stall_events (perf_stall_events)
`endif
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic       iv;
    logic [3:0] ird;
    logic       iwen;
    logic [3:0] r1;
    logic       n1;
    logic [3:0] r2;
    logic       n2;
    logic       wbv;
    logic [3:0] wbrd;
    logic       wbwen;
    logic       fl;
    logic       e_ready;
    logic       e_f1;
    logic       e_f2;
    logic [15:0] e_busy;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [3:0] ird, input logic iwen,
                              input logic [3:0] r1, input logic n1,
                              input logic [3:0] r2, input logic n2,
                              input logic wbv, input logic [3:0] wbrd, input logic fl,
                              input logic er, input logic ef1, input logic ef2,
                              input logic [15:0] eb);
    vec_t v;
    v.iv = iv; v.ird = ird; v.iwen = iwen;
    v.r1 = r1; v.n1 = n1; v.r2 = r2; v.n2 = n2;
    v.wbv = wbv; v.wbrd = wbrd; v.wbwen = wbv; v.fl = fl;
    v.e_ready = er; v.e_f1 = ef1; v.e_f2 = ef2; v.e_busy = eb;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  localparam int W = 19;  // {issue_ready, fwd_rs1, fwd_rs2, busy_mask}
  logic [W-1:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_out(input string name, input logic [W-1:0] exp_v);
    logic [W-1:0] act;
    act = {issue_ready, fwd_rs1, fwd_rs2, busy_mask};
    n_total++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got ready=%0b f1=%0b f2=%0b busy=%h, want ready=%0b f1=%0b f2=%0b busy=%h",
               name, act[18], act[17], act[16], act[15:0],
               exp_v[18], exp_v[17], exp_v[16], exp_v[15:0]);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    issue_valid = v.iv; issue_rd = v.ird; issue_wen = v.iwen;
    rs1 = v.r1; need_rs1 = v.n1; rs2 = v.r2; need_rs2 = v.n2;
    wb_valid = v.wbv; wb_rd = v.wbrd; wb_wen = v.wbwen; flush = v.fl;
  endtask

  task automatic idle_inputs();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0));
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are sampled
  // at the falling edge, then the edge commits the cycle.
  task automatic run_vec(input string name, input vec_t v);
    drive(v);
    #4;
    exp_q.push_back({v.e_ready, v.e_f1, v.e_f2, v.e_busy});
    check_out(name, exp_q.pop_front());
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  int m_cnt[16];

  function automatic bit m_retire(input int r, input logic wbv, input logic wbwen, input logic [3:0] wbrd);
    return (r != 0) && wbv && wbwen && (int'(wbrd) == r);
  endfunction

  vec_t tbl[$];

  initial begin
    vec_t v;
    logic [W-1:0] e;
    reset = 1'b1;
    idle_inputs();

    // Reset state
    #12;
    check_out("reset_state", {1'b1, 1'b0, 1'b0, 16'h0000});
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Directed table, one row per cycle, starting from all counts zero
    tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000)); // issue x5
    tbl.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0020)); // raw hazard
    tbl.push_back(mk(1, 0, 0, 5, 1, 0, 0, 1, 5, 0, 1, 1, 0, 16'h0020)); // forward
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000)); // x5 cleared
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0080));
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0080)); // cnt7=3
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0080)); // saturated
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 0, 0, 16'h0080)); // wb x7
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0080)); // re-enabled
    tbl.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0080));
    tbl.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0088)); // cnt3=2
    tbl.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0088)); // cnt9=1
    tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0288)); // flush
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 1, 0, 0, 16'h0000)); // wb idle x6
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 16'h0000)); // x0 traffic
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2, 1, 1, 2, 0, 1, 0, 1, 16'h0004)); // fwd rs2
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0004)); // cnt2=2
    tbl.push_back(mk(1, 0, 0, 2, 1, 0, 0, 1, 2, 0, 0, 0, 0, 16'h0004)); // no fwd at 2
    tbl.push_back(mk(1, 0, 0, 2, 1, 0, 0, 1, 2, 0, 1, 1, 0, 16'h0004)); // fwd at 1
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000));
    for (int i = 0; i < tbl.size(); i++) begin
      run_vec($sformatf("tbl%0d", i), tbl[i]);
    end

    // Asynchronous reset mid-operation: counts vanish without an edge
    run_vec("pre_arst_a", mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000));
    run_vec("pre_arst_b", mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0002));
    idle_inputs();
    #2;
    check_out("pre_arst_c", {1'b1, 1'b0, 1'b0, 16'h0006});
    reset = 1'b1;
    #1;
    check_out("async_reset", {1'b1, 1'b0, 1'b0, 16'h0000});
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Randomized traffic against the reference model
    do_reset();
    for (int r = 0; r < 16; r++) m_cnt[r] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit hit1, hit2, f1, f2, full, stall, ready, acc;
      logic [15:0] busy;
      v.iv    = ($urandom_range(0, 9) < 7);
      v.ird   = 4'($urandom_range(0, 7));
      v.iwen  = $urandom_range(0, 3) != 0;
      v.r1    = 4'($urandom_range(0, 7));
      v.n1    = $urandom_range(0, 1);
      v.r2    = 4'($urandom_range(0, 7));
      v.n2    = $urandom_range(0, 1);
      v.wbv   = $urandom_range(0, 1);
      v.wbrd  = 4'($urandom_range(0, 7));
      v.wbwen = $urandom_range(0, 4) != 0;
      v.fl    = ($urandom_range(0, 19) == 0);
      drive(v);

      hit1  = v.n1 && (v.r1 != 0) && (m_cnt[v.r1] > 0);
      hit2  = v.n2 && (v.r2 != 0) && (m_cnt[v.r2] > 0);
      f1    = hit1 && m_retire(int'(v.r1), v.wbv, v.wbwen, v.wbrd) && (m_cnt[v.r1] == 1);
      f2    = hit2 && m_retire(int'(v.r2), v.wbv, v.wbwen, v.wbrd) && (m_cnt[v.r2] == 1);
      full  = v.iwen && (v.ird != 0) && (m_cnt[v.ird] == 3);
      stall = (hit1 && !f1) || (hit2 && !f2) || full;
      ready = !stall && !v.fl;
      acc   = v.iv && ready;
      busy  = '0;
      for (int r = 1; r < 16; r++) busy[r] = (m_cnt[r] > 0);
      exp_q.push_back({ready, f1, f2, busy});

      #4;
      e = exp_q.pop_front();
      check_out($sformatf("rand%0d", cyc), e);

      if (v.fl) begin
        for (int r = 0; r < 16; r++) m_cnt[r] = 0;
      end else begin
        for (int r = 1; r < 16; r++) begin
          int delta;
          delta = 0;
          if (acc && v.iwen && (int'(v.ird) == r)) delta += 1;
          if (m_retire(r, v.wbv, v.wbwen, v.wbrd)) delta -= 1;
          m_cnt[r] += delta;
          if (m_cnt[r] < 0) m_cnt[r] = 0;
        end
      end
      @(posedge clock);
      #1;
    end

`ifdef YSYX_23060236_SB_PERF_EN
    // Four stalled cycles in one burst: 4 cycles, 1 event
    do_reset();
    check_word("perf_cycles_rst", perf_stall_cycles, 32'd0);
    check_word("perf_events_rst", perf_stall_events, 32'd0);
    run_vec("perf_issue", mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000));
    for (int i = 0; i < 4; i++) begin
      run_vec($sformatf("perf_stall%0d", i), mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0020));
    end
    run_vec("perf_idle", mk(0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0020));
    check_word("perf_cycles", perf_stall_cycles, 32'd4);
    check_word("perf_events", perf_stall_events, 32'd1);
    run_vec("perf_stall_again", mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0020));
    check_word("perf_cycles2", perf_stall_cycles, 32'd5);
    check_word("perf_events2", perf_stall_events, 32'd2);
`endif

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060236_scoreboard.md
YSYX_23060236_SCOREBOARD -- requirements
Module: ysyx_23060236_scoreboard

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port issue_valid, input, 1, decode stage offers an instruction this cycle.
REQ-004 SHALL have port issue_rd, input, 4, destination register of the offered instruction.
REQ-005 SHALL have port issue_wen, input, 1, offered instruction writes issue_rd.
REQ-006 SHALL have ports rs1 and rs2, input, 4 each, source registers of the offered instruction.
REQ-007 SHALL have ports need_rs1 and need_rs2, input, 1 each, the instruction reads rs1 or rs2.
REQ-008 SHALL have port wb_valid, input, 1, a writeback retires this cycle.
REQ-009 SHALL have port wb_rd, input, 4, writeback destination.
REQ-010 SHALL have port wb_wen, input, 1, the writeback writes the register file.
REQ-011 SHALL have port flush, input, 1, mispredict kill (jump_wrong).
REQ-012 SHALL have port issue_ready, output, 1, offered instruction may be accepted.
REQ-013 SHALL have port fwd_rs1 and fwd_rs2, output, 1 each, select the writeback value for that source this cycle.
REQ-014 SHALL have port busy_mask, output, 16, bit r set when cnt[r] != 0.

Function
REQ-015 SHALL hold a 2-bit pending-write counter cnt[r] for r = 1..15; cnt[0] SHALL be constant 0.
REQ-016 SHALL define retire(r) = wb_valid & wb_wen & (wb_rd == r) & (r != 0).
REQ-017 SHALL define hit1 = need_rs1 & (rs1 != 0) & (cnt[rs1] != 0); hit2 is the same for rs2.
REQ-018 SHALL set fwd_rs1 = hit1 & retire(rs1) & (cnt[rs1] == 1); fwd_rs2 is the same for rs2.
REQ-019 SHALL stall = (hit1 & ~fwd_rs1) | (hit2 & ~fwd_rs2) | (issue_wen & issue_rd != 0 & cnt[issue_rd] == 3).
REQ-020 SHALL drive issue_ready = ~stall & ~flush; this is combinational, with zero latency.
REQ-021 SHALL accept an instruction when issue_valid & issue_ready.
REQ-022 SHALL have each edge perform cnt[r] <= cnt[r] + accept & issue_wen & (issue_rd == r) - retire(r).
REQ-023 SHALL leave cnt[r] unchanged on a simultaneous accept and retire to the same r.
REQ-024 SHALL ignore a retire when cnt[r] == 0, so the counter saturates at 0 and never wraps to 3.
REQ-025 SHALL never increment a counter past 3; REQ-019 blocks that issue.
REQ-026 SHALL, on flush, clear all counters to 0 at the next edge, overriding accept and retire in the same cycle.
REQ-027 SHALL treat writebacks arriving after a flush under the REQ-024 rule.
REQ-028 SHALL keep issue_valid = 0 from affecting any counter.

Reset
REQ-029 SHALL, while reset is high, asynchronously clear all cnt[r] to 0, so that busy_mask = 16'h0000.
REQ-030 SHALL have issue_ready = 1 and fwd_rs1 = fwd_rs2 = 0 under reset, given flush = 0.
REQ-031 SHALL, if reset asserts mid-operation, discard all pending counts immediately, with no edge required.

Configuration
REQ-032 SHALL recognise the macro YSYX_23060236_SB_PERF_EN.
REQ-033 SHALL, when the macro is defined, add output ports perf_stall_cycles [31:0] and perf_stall_events [31:0].
REQ-034 SHALL increment perf_stall_cycles in each cycle with issue_valid & stall.
REQ-035 SHALL increment perf_stall_events on each rising edge of that condition.
REQ-036 SHALL have both performance counters wrap modulo 2^32 and reset to 0.
REQ-037 SHALL, when the macro is undefined, omit both performance ports and their registers; all other behaviour is identical.

Verification
REQ-038 SHALL cover this scenario: issue x5 write, next cycle offer need_rs1 with rs1 = 5 and no wb -> issue_ready = 0 and busy_mask = 16'h0020.
REQ-039 SHALL cover this scenario: cnt[5] = 1, offer rs1 = 5 while wb_valid, wb_wen and wb_rd = 5 -> issue_ready = 1, fwd_rs1 = 1, and cnt[5] is 0 next cycle.
REQ-040 SHALL cover this scenario: three back-to-back issues writing x7 with no wb -> cnt[7] = 3, a fourth write-issue to x7 has issue_ready = 0, and one wb to x7 re-enables it.
REQ-041 SHALL cover this scenario: cnt[3] = 2, cnt[9] = 1, flush asserted together with an accept to x4 -> next cycle busy_mask = 16'h0000.
REQ-042 SHALL cover this scenario: wb to x6 with cnt[6] = 0 -> cnt[6] stays 0 and busy_mask[6] = 0.
REQ-043 SHALL cover this scenario: issue and writeback to x0, and rs1 = 0 with need_rs1 -> busy_mask[0] = 0 and issue_ready = 1; with PERF_EN, 4 stalled cycles -> perf_stall_cycles = 4 and perf_stall_events = 1.
